// File: rtl/bcd_sseg_mux.sv
// Binary-to-BCD (double-dabble) converter driving a 4-digit multiplexed seven-segment display.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros in the hundreds and tens digits.
module bcd_sseg_mux #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  entrada,
  output logic [7:0]  sseg,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]              sh_q, sh_d;
  logic [11:0]             scr_q, scr_d;
  logic [2:0]              iter_q, iter_d;
  logic [7:0]              last_q, last_d;
  logic                    force_q, force_d;
  logic [11:0]             bcd_q, bcd_d;
  logic                    busy_q, busy_d;
  logic [3:0]              an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;

  logic [11:0] scr_adj;
  logic [1:0]  sel;
  logic [3:0]  digit;
  logic        blank;
  logic        blank_h;
  logic        blank_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign scr_adj = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    iter_d  = iter_q;
    last_d  = last_q;
    force_d = force_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if ((entrada != last_q) || force_q) begin
          sh_d    = entrada;
          last_d  = entrada;
          scr_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          force_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, sh_d} = {scr_adj, sh_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = scr_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_h = (bcd_q[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd_q[7:4] == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  assign cnt_d = cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  assign sel   = cnt_q[REFRESH_BITS-1:REFRESH_BITS-2];

  always_comb begin
    an_d  = 4'b0111;
    digit = 4'd0;
    blank = 1'b1;
    unique case (sel)
      2'd0: begin
        an_d  = 4'b1110;
        digit = bcd_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        an_d  = 4'b1101;
        digit = bcd_q[7:4];
        blank = blank_t;
      end
      2'd2: begin
        an_d  = 4'b1011;
        digit = bcd_q[11:8];
        blank = blank_h;
      end
      default: begin
        an_d  = 4'b0111;
        digit = 4'd0;
        blank = 1'b1;
      end
    endcase
    sseg_d = blank ? 8'hFF : seg7(digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      force_q <= 1'b1;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      an_q    <= 4'b1111;
      sseg_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      force_q <= force_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
    end
  end

  assign sseg = sseg_q;
  assign an   = an_q;
  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bcd_sseg_mux.sv
// Scoreboard bench for bcd_sseg_mux: converted values are queued at stimulus
// time and checked when busy falls; display scans are checked per digit.
module tb_bcd_sseg_mux;

  logic        clk;
  logic        rst_n;
  logic [7:0]  entrada;
  logic [7:0]  sseg;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic        busy_prev = 1'b0;

  bcd_sseg_mux #(.REFRESH_BITS(4)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .entrada (entrada),
    .sseg    (sseg),
    .an      (an),
    .bcd     (bcd),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each completed conversion (busy falling) is compared to the queue
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bcd_unexpected: got %0h expected none", bcd);
        end else begin
          chk("bcd_sb", {20'd0, bcd}, {20'd0, exp_q.pop_front()});
        end
      end
      busy_prev = busy;
    end
  end

  task automatic wait_idle();
    bool_loop: begin
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (exp_q.size() == 0 && !busy) disable bool_loop;
      end
      checks++;
      failures++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic show_check(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2);
    logic [3:0] pat[4];
    logic [7:0] exp_s[4];
    logic       seen;
    pat   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_s = '{s0, s1, s2, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
        @(negedge clk);
        if (an == pat[k]) seen = 1'b1;
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL an_timeout: got an=%b expected %b", an, pat[k]);
      end else begin
        chk($sformatf("sseg_digit%0d", k), {24'd0, sseg}, {24'd0, exp_s[k]});
      end
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] e);
    @(posedge clk);
    #1 entrada = v;
    exp_q.push_back(e);
    wait_idle();
  endtask

  logic [3:0] an_last;
  int         bad;
  int         ntrans;

  initial begin
    rst_n   = 1'b1;
    entrada = 8'hAB;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_sseg", {24'd0, sseg}, 32'hFF);
    chk("rst_bcd", {20'd0, bcd}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);

    exp_q.push_back(12'h171);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("busy_after_release", {31'd0, busy}, 32'h1);
    repeat (8) @(posedge clk);
    #1 chk("bcd_prev_edge9", {20'd0, bcd}, 32'h0);
    @(posedge clk);
    #1;
    chk("bcd_lat10", {20'd0, bcd}, 32'h171);
    chk("busy_lat10", {31'd0, busy}, 32'h0);
    wait_idle();

    convert(8'd255, 12'h255);
    chk("bcd_255", {20'd0, bcd}, 32'h255);
    show_check(8'h92, 8'h92, 8'hA4);

    convert(8'd7, 12'h007);
`ifdef LEADING_ZERO_BLANK_EN
    show_check(8'hF8, 8'hFF, 8'hFF);
`else
    show_check(8'hF8, 8'hC0, 8'hC0);
`endif

    convert(8'd0, 12'h000);
`ifdef LEADING_ZERO_BLANK_EN
    show_check(8'hC0, 8'hFF, 8'hFF);
`else
    show_check(8'hC0, 8'hC0, 8'hC0);
`endif

    convert(8'd105, 12'h105);
    show_check(8'h92, 8'hC0, 8'hF9);

    // Change input while the first conversion is mid-shift
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h042);
    @(posedge clk);
    #1 entrada = 8'd100;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 entrada = 8'd42;
    chk("busy_mid_shift", {31'd0, busy}, 32'h1);
    wait_idle();
    chk("bcd_42_final", {20'd0, bcd}, 32'h042);

    // Asynchronous reset in the middle of a conversion
    @(posedge clk);
    #1 entrada = 8'd200;
    repeat (4) @(posedge clk);
    #1 chk("busy_before_abort", {31'd0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_bcd", {20'd0, bcd}, 32'h0);
    chk("abort_an", {28'd0, an}, 32'hF);
    chk("abort_sseg", {24'd0, sseg}, 32'hFF);
    exp_q.push_back(12'h200);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("bcd_200_lat10", {20'd0, bcd}, 32'h200);
    wait_idle();

    // Full refresh scan: one anode low, ordered 0,1,2,3,0
    bad    = 0;
    ntrans = 0;
    @(negedge clk);
    an_last = an;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad++;
      if (an != an_last) begin
        ntrans++;
        if (an != {an_last[2:0], an_last[3]}) bad++;
      end
      an_last = an;
    end
    chk("scan_order", bad, 0);
    chk("scan_transitions", ntrans, 5);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_sseg_mux.md
Name: bcd_sseg_mux

Overview:
- Downstream consumer of the PicoBlaze LED/output register.
- Takes an 8-bit unsigned binary value and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Replaces the plain display driver after the output register; the value is shown in decimal, 0..255.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter; the top 2 bits select the digit. Full scan = 2^18 clk = 5.24 ms at 50 MHz.

Ports:
- clk  input  1  system clock; all registers on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- entrada  input  8  binary value to display, unsigned
- sseg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- an  output  4  digit anodes, active-low; an[0] = rightmost
- bcd  output  12  {hundreds,tens,ones} of the last completed conversion
- busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (reset=0, asynchronous):
  - refresh counter = 0; FSM = IDLE; bcd = 0; busy = 0
  - last_val = 0; force_conv = 1; an = 4'b1111; sseg = 8'hFF
- Refresh counter: free-running, wraps 2^REFRESH_BITS-1 -> 0. sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2].
- Digit select, registered (1 clk latency from sel):
  - sel 0 -> an=1110, ones
  - sel 1 -> an=1101, tens
  - sel 2 -> an=1011, hundreds
  - sel 3 -> an=0111, blank (sseg=FF)
- Segment encoding (sseg hex, dp always 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF
- FSM states IDLE, SHIFT, DONE:
  - IDLE: if entrada != last_val or force_conv, then capture sh=entrada, last_val=entrada, clear scratch BCD, iter=0, busy=1, force_conv=0 -> SHIFT.
  - SHIFT, one iteration per clk: each scratch BCD nibble >=5 gets +3, then {scratch,sh} shifts left 1; iter++. After the 8th shift -> DONE.
  - DONE: bcd <= scratch; busy=0 -> IDLE.
- Latency: entrada change to bcd update = 10 clk (1 capture + 8 shift + 1 DONE). The displayed digits follow on the next refresh slot.
- bcd updates atomically in DONE only. Display never shows a partial result.
- entrada changing during SHIFT: ignored until IDLE. The next IDLE compares against last_val and restarts, so the final displayed value always matches a stable entrada.
- Simultaneous DONE and digit select: the display uses the new bcd from the following clk. No glitch beyond one clk.
- Arithmetic: scratch is 12 bits; max 255 -> 0010_0101_0101. No overflow is possible.
- Reset mid-conversion: immediate abort, all state cleared. A conversion of the current entrada starts on the first clk after release, via force_conv.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: the hundreds digit is blanked when it is 0. The tens digit is blanked when hundreds and tens are both 0. Ones is never blanked.
  - 7 -> digits show "  7"
  - 0 -> "  0"
  - 105 -> "105"
- Undefined: all three digits are always shown.
  - 7 -> "007"
- Digit 3 is blank in both builds.

Test Plan:
- Reset: hold reset=0 with entrada=8'hAB and REFRESH_BITS=4 -> an=1111, sseg=FF, bcd=0, busy=0. Release -> busy rises the next clk; after 10 clk bcd=12'h171.
- entrada=8'd255 stable -> bcd=12'h255; sseg across sel 0/1/2/3 = 92, 92, A4, FF with an = 1110, 1101, 1011, 0111.
- entrada=8'd7 -> without macro, sel 0/1/2 sseg = F8, C0, C0. With LEADING_ZERO_BLANK_EN, sseg = F8, FF, FF.
- Change entrada 100 -> 42 at SHIFT iteration 3 -> the first conversion completes with bcd=12'h100. A second conversion starts and gives bcd=12'h042 within 10 clk after returning to IDLE. busy is high for both conversions.
- Assert reset=0 during SHIFT with entrada=200 -> outputs clear asynchronously, without waiting for clk. After release, bcd=12'h200 after 10 clk.
- Refresh wrap: run 2^REFRESH_BITS clk -> sel sequence 0,1,2,3,0 with exactly one an bit low at all times after the first post-reset clk.
